// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered coefficient bank controller for the complex FIR.
// Coefficient writes land in a shadow bank. A complete set is copied to the
// active bank only while the datapath is between frames. FIFO pulls are
// blocked until a set is live, and in the cycle where the set changes.
module fir_coef_bank_ctrl #(
    parameter int unsigned NCOEF  = 15,
    parameter int unsigned COEF_W = 27,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      PushCoef,
    input  logic [4:0]                CoefAddr,
    input  logic [COEF_W-1:0]         CoefI,
    input  logic [COEF_W-1:0]         CoefQ,
    input  logic                      frame_idle,
    input  logic                      pull_req,
    output logic                      pull_grant,
    output logic [NCOEF*COEF_W-1:0]   coef_I_o,
    output logic [NCOEF*COEF_W-1:0]   coef_Q_o,
    output logic                      coef_ready,
    output logic                      swap_pending,
    output logic [NCOEF-1:0]          load_mask,
    output logic                      addr_err,
    output logic [CNT_W-1:0]          swap_count
);

    localparam int unsigned IDX_W  = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int unsigned BANK_W = NCOEF * COEF_W;

    // Registered state
    logic [BANK_W-1:0] r_shadow_i;
    logic [BANK_W-1:0] r_shadow_q;
    logic [BANK_W-1:0] r_active_i;
    logic [BANK_W-1:0] r_active_q;
    logic [NCOEF-1:0]  r_load_mask;
    logic              r_swap_pending;
    logic              r_coef_ready;
    logic              r_addr_err;
    logic [CNT_W-1:0]  r_swap_count;

    // Decoded write and commit controls
    logic              w_push_legal;
    logic              w_push_illegal;
    logic [IDX_W-1:0]  w_idx;
    logic              w_swap_now;
    logic [BANK_W-1:0] w_shadow_nxt_i;
    logic [BANK_W-1:0] w_shadow_nxt_q;
    logic [NCOEF-1:0]  w_mask_nxt;
    logic              w_mask_full;

    // Address decode: legal range is 1..NCOEF, entry index is address minus one
    always_comb begin
        w_push_legal   = 1'b0;
        w_push_illegal = 1'b0;
        w_idx          = IDX_W'(CoefAddr - 5'd1);
        if (PushCoef) begin
            if ((CoefAddr != 5'd0) && (CoefAddr <= 5'(NCOEF))) begin
                w_push_legal = 1'b1;
            end else begin
                w_push_illegal = 1'b1;
            end
        end
    end

    assign w_swap_now = r_swap_pending & frame_idle;

    // Shadow bank with the current-cycle write merged in; also feeds the commit
    always_comb begin
        w_shadow_nxt_i = r_shadow_i;
        w_shadow_nxt_q = r_shadow_q;
        for (int unsigned k = 0; k < NCOEF; k++) begin
            if (w_push_legal && (w_idx == IDX_W'(k))) begin
                w_shadow_nxt_i[k*COEF_W +: COEF_W] = CoefI;
                w_shadow_nxt_q[k*COEF_W +: COEF_W] = CoefQ;
            end
        end
    end

    // Load mask: a commit clears it and swallows any same-cycle write
    always_comb begin
        w_mask_nxt = r_load_mask;
        if (w_swap_now) begin
            w_mask_nxt = '0;
        end else if (w_push_legal) begin
            for (int unsigned k = 0; k < NCOEF; k++) begin
                if (w_idx == IDX_W'(k)) begin
                    w_mask_nxt[k] = 1'b1;
                end
            end
        end
        w_mask_full = (w_mask_nxt == {NCOEF{1'b1}});
    end

    // Shadow bank register, written on every legal push
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_shadow_i <= '0;
            r_shadow_q <= '0;
        end else begin
            r_shadow_i <= w_shadow_nxt_i;
            r_shadow_q <= w_shadow_nxt_q;
        end
    end

    // Active bank register, changes only on a commit edge
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_active_i <= '0;
            r_active_q <= '0;
        end else if (w_swap_now) begin
            r_active_i <= w_shadow_nxt_i;
            r_active_q <= w_shadow_nxt_q;
        end
    end

    // Load tracking and commit bookkeeping
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_load_mask    <= '0;
            r_swap_pending <= 1'b0;
            r_coef_ready   <= 1'b0;
            r_swap_count   <= '0;
        end else begin
            r_load_mask <= w_mask_nxt;
            if (w_swap_now) begin
                r_swap_pending <= 1'b0;
                r_coef_ready   <= 1'b1;
                r_swap_count   <= r_swap_count + CNT_W'(1);
            end else if (w_mask_full) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // One-cycle pulse flagging an out-of-range write address
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_push_illegal;
        end
    end

    assign pull_grant   = pull_req & r_coef_ready & ~w_swap_now;
    assign coef_I_o     = r_active_i;
    assign coef_Q_o     = r_active_q;
    assign coef_ready   = r_coef_ready;
    assign swap_pending = r_swap_pending;
    assign load_mask    = r_load_mask;
    assign addr_err     = r_addr_err;
    assign swap_count   = r_swap_count;

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed bench for fir_coef_bank_ctrl with hand-computed expectations.
module tb_fir_coef_bank_ctrl;

    localparam int unsigned NCOEF  = 15;
    localparam int unsigned COEF_W = 27;
    localparam int unsigned CNT_W  = 8;

    logic                     clk;
    logic                     Reset;
    logic                     PushCoef;
    logic [4:0]               CoefAddr;
    logic [COEF_W-1:0]        CoefI;
    logic [COEF_W-1:0]        CoefQ;
    logic                     frame_idle;
    logic                     pull_req;
    logic                     pull_grant;
    logic [NCOEF*COEF_W-1:0]  coef_I_o;
    logic [NCOEF*COEF_W-1:0]  coef_Q_o;
    logic                     coef_ready;
    logic                     swap_pending;
    logic [NCOEF-1:0]         load_mask;
    logic                     addr_err;
    logic [CNT_W-1:0]         swap_count;

    int n_checks;
    int n_errors;

    fir_coef_bank_ctrl #(.NCOEF(NCOEF), .COEF_W(COEF_W), .CNT_W(CNT_W)) u_dut (
        .clk          (clk),
        .Reset        (Reset),
        .PushCoef     (PushCoef),
        .CoefAddr     (CoefAddr),
        .CoefI        (CoefI),
        .CoefQ        (CoefQ),
        .frame_idle   (frame_idle),
        .pull_req     (pull_req),
        .pull_grant   (pull_grant),
        .coef_I_o     (coef_I_o),
        .coef_Q_o     (coef_Q_o),
        .coef_ready   (coef_ready),
        .swap_pending (swap_pending),
        .load_mask    (load_mask),
        .addr_err     (addr_err),
        .swap_count   (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [COEF_W-1:0] ent(input logic [NCOEF*COEF_W-1:0] bus, input int k);
        return bus[k*COEF_W +: COEF_W];
    endfunction

    // Advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input int vi, input int vq);
        PushCoef = 1'b1;
        CoefAddr = 5'(addr);
        CoefI    = COEF_W'(vi);
        CoefQ    = COEF_W'(vq);
        cycle();
        PushCoef = 1'b0;
        CoefAddr = 5'd0;
    endtask

    logic [COEF_W-1:0] e;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        Reset      = 1'b1;
        PushCoef   = 1'b0;
        CoefAddr   = 5'd0;
        CoefI      = '0;
        CoefQ      = '0;
        frame_idle = 1'b1;
        pull_req   = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(coef_ready), 32'd0);
        check("rst_pend", 32'(swap_pending), 32'd0);
        check("rst_mask", 32'(load_mask), 32'd0);
        check("rst_cnt", 32'(swap_count), 32'd0);
        check("rst_bank_i0", 32'(coef_I_o == '0), 32'd1);
        check("rst_grant", 32'(pull_grant), 32'd0);

        // T1/T2: first load with frame_idle high throughout
        for (int k = 1; k <= 14; k++) begin
            write(k, k, -k);
            check("t2_grant_load", 32'(pull_grant), 32'd0);
        end
        check("t1_pend_early", 32'(swap_pending), 32'd0);
        write(15, 15, -15);
        check("t1_pend", 32'(swap_pending), 32'd1);
        check("t1_mask_full", 32'(load_mask), 32'h7FFF);
        check("t2_grant_commit", 32'(pull_grant), 32'd0);
        check("t1_active_old", 32'(ent(coef_I_o, 14)), 32'd0);
        cycle();
        check("t1_i14", 32'(ent(coef_I_o, 14)), 32'd15);
        e = COEF_W'(-1);
        check("t1_q0", 32'(ent(coef_Q_o, 0)), 32'(e));
        e = COEF_W'(-8);
        check("t1_q7", 32'(ent(coef_Q_o, 7)), 32'(e));
        check("t1_ready", 32'(coef_ready), 32'd1);
        check("t1_cnt", 32'(swap_count), 32'd1);
        check("t1_mask", 32'(load_mask), 32'd0);
        check("t1_pend_clr", 32'(swap_pending), 32'd0);
        check("t2_grant_on", 32'(pull_grant), 32'd1);

        // T3: reload held off by frame_idle low
        frame_idle = 1'b0;
        for (int k = 1; k <= 15; k++) write(k, 100 + k, -k);
        check("t3_pend", 32'(swap_pending), 32'd1);
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("t3_hold_i0", 32'(ent(coef_I_o, 0)), 32'd1);
        end
        check("t3_pend_hold", 32'(swap_pending), 32'd1);
        check("t3_grant_wait", 32'(pull_grant), 32'd1);
        frame_idle = 1'b1;
        #1;
        check("t3_grant_commit", 32'(pull_grant), 32'd0);
        cycle();
        check("t3_i0", 32'(ent(coef_I_o, 0)), 32'd101);
        check("t3_i14", 32'(ent(coef_I_o, 14)), 32'd115);
        check("t3_cnt", 32'(swap_count), 32'd2);
        check("t3_grant_after", 32'(pull_grant), 32'd1);

        // T4: illegal addresses
        write(0, 7, 7);
        check("t4_err0", 32'(addr_err), 32'd1);
        check("t4_mask0", 32'(load_mask), 32'd0);
        cycle();
        check("t4_err_clr", 32'(addr_err), 32'd0);
        write(16, 7, 7);
        check("t4_err16", 32'(addr_err), 32'd1);
        check("t4_mask16", 32'(load_mask), 32'd0);
        check("t4_pend", 32'(swap_pending), 32'd0);
        write(1, 5, 5);
        check("t4_err_legal", 32'(addr_err), 32'd0);
        check("t4_mask_legal", 32'(load_mask), 32'd1);
        check("t4_active", 32'(ent(coef_I_o, 0)), 32'd101);

        // T5: rewrite of one address, last value wins
        frame_idle = 1'b0;
        write(5, 7, 0);
        write(5, 9, 0);
        check("t5_mask_once", 32'(load_mask), 32'h0011);
        for (int k = 1; k <= 15; k++) begin
            if (k != 5) write(k, 200 + k, 0);
        end
        check("t5_pend", 32'(swap_pending), 32'd1);
        frame_idle = 1'b1;
        cycle();
        check("t5_i4", 32'(ent(coef_I_o, 4)), 32'd9);
        check("t5_i0", 32'(ent(coef_I_o, 0)), 32'd201);
        check("t5_cnt", 32'(swap_count), 32'd3);

        // T6: write forwarded into the commit cycle
        frame_idle = 1'b0;
        for (int k = 1; k <= 15; k++) write(k, 300 + k, 0);
        check("t6_pend", 32'(swap_pending), 32'd1);
        frame_idle = 1'b1;
        write(3, 32'h55, 32'h12);
        check("t6_i2", 32'(ent(coef_I_o, 2)), 32'h55);
        check("t6_q2", 32'(ent(coef_Q_o, 2)), 32'h12);
        check("t6_i0", 32'(ent(coef_I_o, 0)), 32'd301);
        check("t6_mask", 32'(load_mask), 32'd0);
        check("t6_pend_clr", 32'(swap_pending), 32'd0);
        check("t6_cnt", 32'(swap_count), 32'd4);
        cycle();
        check("t6_mask_next", 32'(load_mask), 32'd0);

        // T7: reset mid-load dominates a concurrent illegal push
        frame_idle = 1'b0;
        for (int k = 1; k <= 8; k++) write(k, 400 + k, 1);
        check("t7_mask_pre", 32'(load_mask), 32'h00FF);
        check("t7_ready_pre", 32'(coef_ready), 32'd1);
        Reset    = 1'b1;
        PushCoef = 1'b1;
        CoefAddr = 5'd0;
        cycle();
        PushCoef = 1'b0;
        check("t7_mask", 32'(load_mask), 32'd0);
        check("t7_ready", 32'(coef_ready), 32'd0);
        check("t7_cnt", 32'(swap_count), 32'd0);
        check("t7_pend", 32'(swap_pending), 32'd0);
        check("t7_err", 32'(addr_err), 32'd0);
        check("t7_bank_i", 32'(coef_I_o == '0), 32'd1);
        check("t7_bank_q", 32'(coef_Q_o == '0), 32'd1);
        check("t7_grant", 32'(pull_grant), 32'd0);
        Reset = 1'b0;
        cycle();
        check("t7_grant_after", 32'(pull_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
